// File: rtl/path_fifo.sv
// path_fifo: 4-entry single-clock first-word-fall-through FIFO.
//
// Handshake: a word is accepted from the producer in any cycle where
// enq=1 and busy=0; a word is delivered to the consumer in any cycle where
// deq=1 and valid=1. Both responses are combinational in the request cycle,
// and the resulting state change commits at the next rising edge of clk.
// When the FIFO is empty, enq=deq=1 passes d_in straight to d_out and
// stores nothing.
//
// Storage is a circular buffer addressed by rd_ptr/wr_ptr. A popped slot is
// cleared to zero so that vacated entries never hold stale data.
module path_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  enq,
    input  logic                  deq,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  valid,
    output logic                  busy,
    output logic [2:0]            c_out
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]      FULL_CNT = 3'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [2:0]            count;

    logic                  empty;
    logic                  full;
    logic [DATA_WIDTH-1:0] head;
    logic                  bypass;
    logic                  do_push;
    logic                  do_pop;

    // Advance a circular pointer, wrapping after the last storage slot.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        ptr_next = (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Request decode and status outputs, all derived from the current request
    // and the stored occupancy.
    always_comb begin
        empty   = (count == 3'd0);
        full    = (count == FULL_CNT);
        head    = empty ? '0 : mem[rd_ptr];
        bypass  = enq && deq && empty;
        // A full FIFO still accepts when the head leaves in the same cycle.
        busy    = enq && !deq && full;
        valid   = deq && (!empty || enq);
        d_out   = bypass ? d_in : head;
        do_pop  = deq && !empty;
        do_push = enq && !busy && !bypass;
        c_out   = count;
    end

    // Commit pops, pushes and occupancy; reset clears everything and
    // overrides any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 3'd0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                mem[rd_ptr] <= '0;
                rd_ptr      <= ptr_next(rd_ptr);
            end
            // When full with enq=deq=1, wr_ptr equals rd_ptr; the write below
            // is placed after the clear so the new word wins that slot.
            if (do_push) begin
                mem[wr_ptr] <= d_in;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_path_fifo.sv
// tb_path_fifo: directed and randomized checks of path_fifo against a
// queue-based reference model. The driver issues one request per cycle and
// pushes the expected response; a monitor pops and compares each cycle.
module tb_path_fifo;

    localparam int DW = 32;
    localparam int W  = 1 + 1 + 3 + DW;  // {valid, busy, c_out, d_out}

    logic          clk;
    logic          rst;
    logic [DW-1:0] d_in;
    logic          enq;
    logic          deq;
    logic [DW-1:0] d_out;
    logic          valid;
    logic          busy;
    logic [2:0]    c_out;

    int tests_run;
    int tests_failed;

    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] model_q[$];
    logic          last_accepted;

    path_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .enq   (enq),
        .deq   (deq),
        .d_out (d_out),
        .valid (valid),
        .busy  (busy),
        .c_out (c_out)
    );

    // Clock and initial input levels.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst  = 1'b1;
        enq  = 1'b0;
        deq  = 1'b0;
        d_in = '0;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one request for the coming cycle. The reference model is a plain
    // queue of at most 4 words; the expected response is derived from it and
    // the model then advances to its post-edge contents.
    task automatic step(input logic r, input logic e, input logic dq, input logic [DW-1:0] din);
        logic          m_valid;
        logic          m_busy;
        logic [DW-1:0] m_dout;
        int            n;
        @(posedge clk);
        #1;
        rst  = r;
        enq  = e;
        deq  = dq;
        d_in = din;
        last_accepted = 1'b0;
        if (r) begin
            model_q.delete();
        end else begin
            n       = model_q.size();
            m_busy  = e && !dq && (n == 4);
            m_valid = dq && (n > 0 || e);
            if (n == 0) m_dout = (e && dq) ? din : '0;
            else        m_dout = model_q[0];
            exp_q.push_back({m_valid, m_busy, 3'(n), m_dout});
            last_accepted = e && !m_busy;
            if (dq && n > 0) void'(model_q.pop_front());
            if (last_accepted && !(dq && n == 0)) model_q.push_back(din);
        end
    endtask

    // Monitor: compare the DUT response mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("valid", DW'(valid), DW'(exp_v[W-1]));
            chk("busy",  DW'(busy),  DW'(exp_v[W-2]));
            chk("c_out", DW'(c_out), DW'(exp_v[W-3:W-5]));
            chk("d_out", d_out, exp_v[DW-1:0]);
        end
    end

    initial begin
        logic [DW-1:0] word;
        tests_run     = 0;
        tests_failed  = 0;
        last_accepted = 1'b0;

        // Reset, then idle: everything reads zero.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Fill with 1..4, then an overflow attempt with 5.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
        step(1'b0, 1'b1, 1'b0, 32'd5);
        step(1'b0, 1'b0, 1'b0, '0);

        // Drain 1..4, then an underflow attempt.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, '0);

        // Bypass on empty, then confirm nothing was stored.
        step(1'b0, 1'b1, 1'b1, 32'h2A);
        step(1'b0, 1'b0, 1'b0, '0);

        // Simultaneous enq/deq while full, then drain 2,3,4,9.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
        step(1'b0, 1'b1, 1'b1, 32'd9);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, '0);

        // Random soak with an incrementing data stream and one mid-run reset.
        word = 32'd100;
        for (int c = 0; c < 500; c++) begin
            if (c == 250) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word);
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), word);
                if (last_accepted) word = word + 32'd1;
            end
        end
        step(1'b0, 1'b0, 1'b0, '0);

        // Let the monitor consume the last expectations, bounded by cycles.
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("exp_q_drained", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
